// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: fetch window defaults, NOP encoding, IF/ID payload.
package mips_defs;

  localparam int unsigned XLEN            = 32;
  localparam logic [31:0] DEF_RESET_PC    = 32'h0000_3000;
  localparam int unsigned DEF_IMEM_WORDS  = 1024;
  localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;

  typedef enum logic [1:0] {
    SRC_SEQ   = 2'd0,
    SRC_REDIR = 2'd1,
    SRC_HOLD  = 2'd2,
    SRC_FLUSH = 2'd3
  } npc_src_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
    logic            fault;
  } ifid_t;

endpackage

// File: rtl/npc_sel.sv
// Next-PC priority mux: flush over stall over redirect over sequential.
module npc_sel
  import mips_defs::*;
(
  input  logic            flush,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [XLEN-1:0] flush_pc,
  output logic [XLEN-1:0] npc,
  output npc_src_e        src
);

  always_comb begin
    src = SRC_SEQ;
    npc = pc + 32'd4;
    if (flush) begin
      src = SRC_FLUSH;
      npc = flush_pc;
    end else if (stall) begin
      // redirect stays pending in ID until the stall releases
      src = SRC_HOLD;
      npc = pc;
    end else if (redirect) begin
      src = SRC_REDIR;
      npc = redirect_pc;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: PC register, fetch-window check and IF/ID pipeline register.
module ifu_fetch
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter int unsigned IMEM_WORDS = DEF_IMEM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic        id_fault
);

  // Window bounds carried in 33 bits so the upper limit never wraps.
  localparam logic [32:0] WIN_LO = 33'(RESET_PC);
  localparam logic [32:0] WIN_HI = 33'(RESET_PC) + (33'(IMEM_WORDS) << 2);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] npc;
  npc_src_e        src;
  ifid_t           ifid;
  logic            fetch_ok;
  logic [XLEN-1:0] fetch_word;

  npc_sel u_npc_sel (
    .flush       (flush),
    .stall       (stall),
    .redirect    (redirect),
    .pc          (pc),
    .redirect_pc (redirect_pc),
    .flush_pc    (flush_pc),
    .npc         (npc),
    .src         (src)
  );

  always_comb begin
    fetch_ok   = (pc[1:0] == 2'b00) && ({1'b0, pc} >= WIN_LO) && ({1'b0, pc} < WIN_HI);
    fetch_word = fetch_ok ? imem_instr : NOP_INSTR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc   <= RESET_PC;
      ifid <= '{instr: NOP_INSTR, pc: RESET_PC, valid: 1'b0, fault: 1'b0};
    end else begin
      pc <= npc;
      unique case (src)
        SRC_FLUSH: begin
          ifid.instr <= NOP_INSTR;
          ifid.valid <= 1'b0;
          ifid.fault <= 1'b0;
        end
        SRC_HOLD: ifid <= ifid;
        // redirect keeps the delay-slot word, same as a sequential fetch
        default: ifid <= '{instr: fetch_word, pc: pc, valid: 1'b1, fault: ~fetch_ok};
      endcase
    end
  end

  assign imem_pc  = pc;
  assign id_instr = ifid.instr;
  assign id_pc    = ifid.pc;
  assign id_pc8   = ifid.pc + 32'd8;
  assign id_valid = ifid.valid;
  assign id_fault = ifid.fault;

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction-fetch stage that owns the program counter and the IF/ID pipeline register. Drives the word address into the combinational instruction memory (`im`), which returns the instruction the same cycle. Latches that instruction into IF/ID for the decode stage. Applies stall, branch/jump redirect (MIPS delay-slot semantics) and exception flush.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value after reset.
- `IMEM_WORDS`, default 1024: instruction memory depth in words; defines the legal fetch window.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `stall`  in  1: hazard stall from decode; hold PC and IF/ID.
- `redirect`  in  1: branch taken or jump resolved in ID.
- `redirect_pc`  in  32: target for `redirect`.
- `flush`  in  1: exception/eret flush.
- `flush_pc`  in  32: target for `flush`.
- `imem_pc`  out  32: current PC to `im`.
- `imem_instr`  in  32: instruction from `im`, combinational on `imem_pc`.
- `id_instr`  out  32: IF/ID instruction.
- `id_pc`  out  32: IF/ID PC.
- `id_pc8`  out  32: `id_pc + 8`, the link address.
- `id_valid`  out  1: IF/ID holds a real instruction, not a bubble.
- `id_fault`  out  1: IF/ID instruction came from an illegal fetch address.

## Operation
- PC register `pc`; `imem_pc = pc`.
- Fetch is legal when `pc[1:0]==0` and `RESET_PC <= pc < RESET_PC + 4*IMEM_WORDS`, computed on 32-bit unsigned values with no wrap.
  - Legal fetch: the fetched word is `imem_instr`.
  - Illegal fetch: the fetched word is NOP (32'h0) and the fault bit is 1.
- Next-state priority, evaluated once per edge:
  1. `flush`: `pc <= flush_pc`; IF/ID cleared to a bubble (`id_instr=0`, `id_valid=0`, `id_fault=0`; `id_pc` keeps its value). Overrides `stall` and `redirect`.
  2. `stall`: `pc` and IF/ID hold. `redirect` is ignored; ID keeps `redirect` asserted until the stall drops.
  3. `redirect`: `pc <= redirect_pc`. IF/ID loads the fetched word at the current `pc`, which is the delay slot, so it is not squashed.
  4. Otherwise: `pc <= pc + 4`, wrapping mod 2^32. IF/ID loads the fetched word, `id_pc <= pc`, `id_valid <= 1`, `id_fault <= fault`.
- `id_pc8 = id_pc + 8`, combinational, mod 2^32.
- A misaligned `redirect_pc` or `flush_pc` is accepted into `pc` and produces a faulted fetch. It is never silently realigned.

## Timing
- Reset values while `reset=1`, asserted asynchronously:
  - `pc = RESET_PC`, so `imem_pc = RESET_PC`.
  - `id_instr = 0`, `id_pc = RESET_PC`, `id_pc8 = RESET_PC+8`.
  - `id_valid = 0`, `id_fault = 0`.
- After `reset` deasserts: the first edge latches the instruction at `RESET_PC` into IF/ID.
- Latency: 1 cycle from `imem_pc` to `id_instr`. The redirect target is fetched on the cycle after `redirect` is sampled.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately. Pending `redirect`/`flush` are discarded.
- Simultaneous `flush`+`stall`+`redirect`: flush wins, as in the priority list.
- `pc = 32'hFFFF_FFFC` sequential: next `pc = 0`, and the fetch at 0 faults.

## Structure
- Shared package `mips_defs`: `RESET_PC` default, `NOP_INSTR` (32'h0), `IMEM_WORDS`. `im` uses the same `IMEM_WORDS`.
- One sub-module, `npc_sel`: combinational next-PC priority mux (flush/stall/redirect/seq).
- The PC register and IF/ID register stay in `ifu_fetch`.

## Test plan
- Reset then free-run 3 cycles with `im` loaded with 0x3c010001, 0x34210002, 0x00000000.
  - `imem_pc` steps 0x3000, 0x3004, 0x3008, 0x300C.
  - `id_instr` is 0x3c010001 on cycle 1 with `id_pc=0x3000`, `id_pc8=0x3008`, `id_valid=1`.
- Redirect at `pc=0x3010`, `redirect_pc=0x3040`.
  - Next cycle `id_pc=0x3010`, `id_valid=1` (delay slot kept).
  - `imem_pc=0x3040`, and the following cycle `id_pc=0x3040`.
- Stall for 2 cycles with `redirect=1` held throughout.
  - `pc` and IF/ID are frozen both cycles.
  - On release, `pc` loads `redirect_pc` exactly once.
- `flush=1`, `flush_pc=0x4180`, with `stall=1` and `redirect=1` also asserted.
  - Next `pc=0x4180`; `id_valid=0`, `id_instr=0`.
- `redirect_pc=0x4000` (one past the window with defaults).
  - `id_instr=0`, `id_fault=1`.
  - Same for `redirect_pc=0x3002`.
- Assert `reset` asynchronously mid-cycle during a redirect: outputs go to reset values before the next edge, and no redirect is taken after release.
